// File: rtl/uart_rx_fsm.sv
// Oversampled UART receiver: 2-flop input synchronizer, start/data/parity/stop FSM,
// one-clk result pulse carrying data and per-frame error flags.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic                  sample_tick,
   input  logic                  parity_en,
   input  logic                  parity_type,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  parity_err,
   output logic                  stop_err,
   output logic                  busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [1:0]            sync_q;
   logic                  line;
   state_t                state_q, state_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  pen_q, pen_d, ptype_q, ptype_d, perr_q, perr_d;
   logic                  mid, last, done;

   assign line = sync_q[1];
   assign mid  = sample_tick && (tick_q == TICK_MID);
   assign last = sample_tick && (tick_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pen_d   = pen_q;
      ptype_d = ptype_q;
      perr_d  = perr_q;
      done    = 1'b0;
      if (sample_tick)
         tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      case (state_q)
         IDLE: begin
            tick_d = '0;
            if (sample_tick && !line)
               state_d = START;
         end
         START: begin
            if (mid) begin
               if (line) begin
                  state_d = IDLE;
                  tick_d  = '0;
               end else begin
                  // frame configuration is frozen here for the rest of the frame
                  pen_d   = parity_en;
                  ptype_d = parity_type;
                  bit_d   = '0;
                  perr_d  = 1'b0;
               end
            end else if (last) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (mid)
               shift_d = {line, shift_q[DATA_WIDTH-1:1]};
            if (last) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST)
                  state_d = pen_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (mid)
               perr_d = line != (ptype_q ? ~^shift_q : ^shift_q);
            if (last)
               state_d = STOP;
         end
         STOP: begin
            // leave at mid-bit so a back-to-back start edge is not missed
            if (mid) begin
               done    = 1'b1;
               state_d = IDLE;
               tick_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= 2'b11;
         state_q    <= IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         pen_q      <= 1'b0;
         ptype_q    <= 1'b0;
         perr_q     <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         stop_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], rx_in};
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         pen_q      <= pen_d;
         ptype_q    <= ptype_d;
         perr_q     <= perr_d;
         data_valid <= done;
         parity_err <= done & pen_q & perr_q;
         stop_err   <= done & ~line;
         busy       <= (state_d != IDLE);
         if (done)
            data_out <= shift_q;
      end
   end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame, minimum 5, maximum 9.
REQ-002 Parameter: OVERSAMPLE, default 8, sample_tick pulses per bit period, even, minimum 4.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-006 sample_tick  input  1  one-clk-wide enable at OVERSAMPLE x baud rate.
REQ-007 parity_en  input  1  1 = frame carries a parity bit.
REQ-008 parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-009 data_out  output  DATA_WIDTH  last received word.
REQ-010 data_valid  output  1  one-clk pulse; data_out and the error flags are valid.
REQ-011 parity_err  output  1  parity mismatch, qualified by data_valid.
REQ-012 stop_err  output  1  stop bit sampled low, qualified by data_valid.
REQ-013 busy  output  1  high while a frame is in progress.

Function
REQ-014 rx_in SHALL pass through a 2-flop synchronizer whose flops reset to 1; "line" below means the synchronizer output.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with any unused encoding returning to IDLE.
REQ-016 tick_cnt (0..OVERSAMPLE-1) SHALL advance only on sample_tick and wrap to 0.
REQ-017 The mid-bit sample point SHALL be the tick where tick_cnt == OVERSAMPLE/2-1.
REQ-018 IDLE: on a sample_tick with line = 0, the FSM SHALL go to START with tick_cnt = 0; otherwise it stays in IDLE.
REQ-019 START, mid-bit, line = 1: false start; the FSM SHALL return to IDLE with no flags.
REQ-020 START, mid-bit, line = 0: the FSM SHALL latch parity_en/parity_type for the frame and clear bit_cnt.
REQ-021 Changes to parity_en/parity_type during a frame SHALL be ignored.
REQ-022 START to DATA SHALL occur at tick_cnt == OVERSAMPLE-1.
REQ-023 DATA: mid-bit samples SHALL shift into the data register LSB-first.
REQ-024 DATA: at tick_cnt == OVERSAMPLE-1, bit_cnt SHALL increment; at bit_cnt == DATA_WIDTH-1 the FSM goes to PARITY if the latched parity_en = 1, else STOP.
REQ-025 PARITY: the mid-bit sample SHALL be compared with XOR(data) for even parity, or ~XOR(data) for odd; a mismatch records a parity error.
REQ-026 PARITY to STOP SHALL occur at tick_cnt == OVERSAMPLE-1.
REQ-027 STOP, mid-bit tick: stop_err SHALL be recorded as ~line, and the FSM goes directly to IDLE (no wait for bit end), so a back-to-back start bit can be caught.
REQ-028 On the clk after the STOP mid-bit tick, data_out SHALL update; data_valid, parity_err and stop_err are 1 for exactly one clk.
REQ-029 data_valid SHALL be asserted even when either error flag is set.
REQ-030 parity_err SHALL be 0 when parity is disabled.
REQ-031 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-032 busy SHALL be driven from a register.
REQ-033 Between sample_ticks, state and counters SHALL hold.

Reset
REQ-034 On rst = 1 at a clk edge: state = IDLE, tick_cnt = 0, bit_cnt = 0, data_out = 0, data_valid = 0, parity_err = 0, stop_err = 0, busy = 0, synchronizer flops = 1.
REQ-035 Reset mid-frame SHALL abort the frame with no data_valid.
REQ-036 After a mid-frame reset, the next frame SHALL receive correctly.

Verification
REQ-037 8N1 frame 0xA5, OVERSAMPLE = 8 -> one data_valid pulse, data_out = 0xA5, parity_err = 0, stop_err = 0, busy low afterwards.
REQ-038 Frame 0x3C, even parity, parity bit 0 -> parity_err = 0; same frame, parity bit 1 -> data_valid with parity_err = 1.
REQ-039 Line low for 2 ticks then high -> no data_valid, busy returns to 0 after mid-bit, next frame 0x5A received correctly.
REQ-040 Frame 0xFF with stop bit 0 -> data_valid, data_out = 0xFF, stop_err = 1.
REQ-041 Frames 0x01 then 0x80 with no idle gap -> two data_valid pulses, data in order.
REQ-042 rst asserted during DATA bit 4 -> all outputs 0, no data_valid; following frame 0xC3 received correctly.
